// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction memory and
// buffers {pc, inst} pairs in a small FIFO presented to decode via valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned PTR_W    = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_inst,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_dec_valid,
    input  logic        i_dec_ready,
    output logic [31:0] o_dec_inst,
    output logic [31:0] o_dec_pc,
    output logic [31:0] o_fetch_count
);

    localparam logic [PTR_W:0]   CntFull = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CntOne  = 1;
    localparam logic [PTR_W-1:0] PtrOne  = 1;

    logic [31:0]      r_pc;
    logic [PTR_W:0]   r_cnt;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [31:0]      r_fetch_count;
    logic [31:0]      r_fifo_inst [DEPTH];
    logic [31:0]      r_fifo_pc   [DEPTH];

    logic w_pop;
    logic w_full;
    logic w_push;

    always_comb begin
        o_dec_valid = (r_cnt != '0);
        w_pop       = o_dec_valid & i_dec_ready;
        w_full      = (r_cnt == CntFull);
        w_push      = rst & ~i_redirect_valid & (~w_full | w_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_cnt         <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_fetch_count <= '0;
        end else if (i_redirect_valid) begin
            // Flush wins over any concurrent pop; the popped entry is simply dropped.
            r_pc     <= {i_redirect_pc[31:2], 2'b00};
            r_cnt    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr      <= r_wr_ptr + PtrOne;
                r_pc          <= r_pc + 32'd4;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CntOne;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - CntOne;
            end
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_inst[r_wr_ptr] <= i_imem_inst;
            r_fifo_pc[r_wr_ptr]   <= r_pc;
        end
    end

    always_comb begin
        o_imem_addr   = {2'b00, r_pc[31:2]};
        o_dec_inst    = r_fifo_inst[r_rd_ptr];
        o_dec_pc      = r_fifo_pc[r_rd_ptr];
        o_fetch_count = r_fetch_count;
    end

endmodule
